// File: rtl/char_pwm_generator.sv
// Character-bitmap PWM encoder: serializes a 4x4 glyph as 16 fixed-length
// PWM slots on one line. Wide pulses mark lit pixels and narrow pulses mark dark ones.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   char_select - glyph select, 0..3 -> CHAR0..CHAR3, sampled at frame start
//   digit       - registered PWM pixel stream
module char_pwm_generator #(
    parameter int unsigned SLOT_CYCLES = 8,
    parameter int unsigned DUTY_ON     = 6,
    parameter int unsigned DUTY_OFF    = 1,
    parameter logic [15:0] CHAR0       = 16'hF99F,
    parameter logic [15:0] CHAR1       = 16'h2627,
    parameter logic [15:0] CHAR2       = 16'hE3CF,
    parameter logic [15:0] CHAR3       = 16'hF71F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] char_select,
    output logic       digit
);

    localparam logic [7:0]  SLOT_LAST = 8'(SLOT_CYCLES - 1);
    localparam logic [31:0] D_ON      = 32'(DUTY_ON);
    localparam logic [31:0] D_OFF     = 32'(DUTY_OFF);

    logic [7:0]  slot_cnt;
    logic [3:0]  pix_idx;
    logic [1:0]  char_q;

    logic        frame_start;
    logic [1:0]  sel;
    logic [15:0] bitmap;
    logic        lit;
    logic [31:0] duty;
    logic        pulse;

    always_comb begin
        frame_start = (pix_idx == 4'd0) && (slot_cnt == 8'd0);
        // The live input is used on the frame-start cycle itself so the
        // first slot already reflects the new glyph.
        sel    = frame_start ? char_select : char_q;
        bitmap = CHAR0;
        unique case (sel)
            2'd0: bitmap = CHAR0;
            2'd1: bitmap = CHAR1;
            2'd2: bitmap = CHAR2;
            2'd3: bitmap = CHAR3;
        endcase
        // Slot p carries bit 15-p, which is simply the inverted index.
        lit   = bitmap[~pix_idx];
        duty  = lit ? D_ON : D_OFF;
        pulse = {24'd0, slot_cnt} < duty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit    <= 1'b0;
            slot_cnt <= 8'd0;
            pix_idx  <= 4'd0;
            char_q   <= 2'd0;
        end else begin
            digit <= pulse;
            if (frame_start)
                char_q <= char_select;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= 8'd0;
                pix_idx  <= pix_idx + 4'd1;
            end else begin
                slot_cnt <= slot_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_char_pwm_generator.sv
// Self-checking bench for char_pwm_generator: the default instance plus
// a short-slot corner instance, checked against a frame-level waveform model.
module tb_char_pwm_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] char_select = 2'd0;
    logic       digit;

    logic       rst_c = 1'b1;
    logic [1:0] sel_c = 2'd0;
    logic       digit_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    char_pwm_generator u_dut (
        .clk        (clk),
        .rst        (rst),
        .char_select(char_select),
        .digit      (digit)
    );

    char_pwm_generator #(
        .SLOT_CYCLES(4),
        .DUTY_ON    (4),
        .DUTY_OFF   (0)
    ) u_corner (
        .clk        (clk),
        .rst        (rst_c),
        .char_select(sel_c),
        .digit      (digit_c)
    );

    function automatic logic [15:0] glyph(input logic [1:0] s);
        case (s)
            2'd0:    return 16'hF99F;
            2'd1:    return 16'h2627;
            2'd2:    return 16'hE3CF;
            default: return 16'hF71F;
        endcase
    endfunction

    // Expected level at cycle k of a frame: slot k/s shows bit 15-(k/s),
    // high for the first duty cycles of the slot.
    function automatic logic model(input logic [15:0] bmp, input int s,
                                   input int don, input int doff,
                                   input int k);
        int p;
        int c;
        int d;
        p = k / s;
        c = k % s;
        d = bmp[15 - p] ? don : doff;
        return c < d;
    endfunction

    function automatic int frame_highs(input logic [15:0] bmp,
                                       input int don, input int doff);
        int n;
        n = $countones(bmp);
        return n * don + (16 - n) * doff;
    endfunction

    task automatic apply_reset(input logic [1:0] s);
        @(negedge clk);
        rst = 1'b1;
        char_select = s;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic exp8 [8];
        exp8 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset(2'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (digit !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre got %b want 1", digit);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (digit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async got %b want 0", digit);
        end
        @(negedge clk);
        char_select = 2'd0;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (digit !== exp8[k]) begin
                n_err++;
                $display("FAIL reset_first k=%0d got %b want %b",
                         k, digit, exp8[k]);
            end
        end
    endtask

    task automatic test_frame0;
        int hi;
        hi = 0;
        apply_reset(2'd0);
        for (int k = 0; k < 128; k++) begin
            logic e;
            @(posedge clk);
            @(negedge clk);
            e = model(16'hF99F, 8, 6, 1, k);
            if (digit === 1'b1) hi++;
            n_cmp++;
            if (digit !== e) begin
                n_err++;
                $display("FAIL frame0 k=%0d got %b want %b", k, digit, e);
            end
        end
        n_cmp++;
        if (hi != 76) begin
            n_err++;
            $display("FAIL frame0_count got %0d want 76", hi);
        end
    endtask

    // Continues from a frame boundary left by test_frame0.
    task automatic test_sweep;
        int want [3];
        want = '{51, 71, 76};
        for (int s = 1; s <= 3; s++) begin
            char_select = 2'(s);
            for (int f = 0; f < 2; f++) begin
                int hi;
                hi = 0;
                for (int k = 0; k < 128; k++) begin
                    logic e;
                    @(posedge clk);
                    @(negedge clk);
                    e = model(glyph(2'(s)), 8, 6, 1, k);
                    if (digit === 1'b1) hi++;
                    n_cmp++;
                    if (digit !== e) begin
                        n_err++;
                        $display("FAIL sweep s=%0d f=%0d k=%0d got %b want %b",
                                 s, f, k, digit, e);
                    end
                end
                n_cmp++;
                if (hi != want[s-1]) begin
                    n_err++;
                    $display("FAIL sweep_count s=%0d got %0d want %0d",
                             s, hi, want[s-1]);
                end
            end
        end
    endtask

    task automatic test_mid_change;
        apply_reset(2'd0);
        for (int k = 0; k < 256; k++) begin
            logic e;
            if (k == 40) char_select = 2'd1;
            @(posedge clk);
            @(negedge clk);
            e = (k < 128) ? model(16'hF99F, 8, 6, 1, k)
                          : model(16'h2627, 8, 6, 1, k - 128);
            n_cmp++;
            if (digit !== e) begin
                n_err++;
                $display("FAIL mid_change k=%0d got %b want %b", k, digit, e);
            end
        end
    endtask

    task automatic test_periodicity;
        apply_reset(2'd3);
        for (int f = 0; f < 5; f++) begin
            int hi;
            hi = 0;
            for (int k = 0; k < 128; k++) begin
                logic e;
                @(posedge clk);
                @(negedge clk);
                e = model(16'hF71F, 8, 6, 1, k);
                if (digit === 1'b1) hi++;
                n_cmp++;
                if (digit !== e) begin
                    n_err++;
                    $display("FAIL period f=%0d k=%0d got %b want %b",
                             f, k, digit, e);
                end
            end
            n_cmp++;
            if (hi != 76) begin
                n_err++;
                $display("FAIL period_count f=%0d got %0d want 76", f, hi);
            end
        end
    endtask

    // Random glyph per frame with random mid-frame glitches on the select
    // that must be ignored; continues on a frame boundary.
    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            logic [1:0] s;
            int         chg;
            int         hi;
            s   = 2'($urandom_range(0, 3));
            chg = $urandom_range(1, 127);
            hi  = 0;
            char_select = s;
            for (int k = 0; k < 128; k++) begin
                logic e;
                if (k == chg) char_select = 2'($urandom_range(0, 3));
                @(posedge clk);
                @(negedge clk);
                e = model(glyph(s), 8, 6, 1, k);
                if (digit === 1'b1) hi++;
                n_cmp++;
                if (digit !== e) begin
                    n_err++;
                    $display("FAIL random f=%0d sel=%0d k=%0d got %b want %b",
                             f, s, k, digit, e);
                end
            end
            n_cmp++;
            if (hi != frame_highs(glyph(s), 6, 1)) begin
                n_err++;
                $display("FAIL random_count f=%0d got %0d want %0d",
                         f, hi, frame_highs(glyph(s), 6, 1));
            end
        end
    endtask

    task automatic test_corner;
        int hi;
        hi = 0;
        @(negedge clk);
        rst_c = 1'b1;
        sel_c = 2'd0;
        @(negedge clk);
        rst_c = 1'b0;
        for (int k = 0; k < 128; k++) begin
            logic e;
            @(posedge clk);
            @(negedge clk);
            e = model(16'hF99F, 4, 4, 0, k % 64);
            if (k < 64 && digit_c === 1'b1) hi++;
            n_cmp++;
            if (digit_c !== e) begin
                n_err++;
                $display("FAIL corner k=%0d got %b want %b", k, digit_c, e);
            end
        end
        n_cmp++;
        if (hi != 48) begin
            n_err++;
            $display("FAIL corner_count got %0d want 48", hi);
        end
    endtask

    initial begin
        test_reset;
        test_frame0;
        test_sweep;
        test_random;
        test_mid_change;
        test_periodicity;
        test_corner;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
